disp_capture: RTL and testbench
===============================

DISP_CAPTURE -- requirements
Module: disp_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, consecutive cycles Dig/Seg must hold before a digit is sampled.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Dig  input  4  active-low digit enables; 0111 = color letter, 1011 = hundreds, 1101 = tens, 1110 = ones.
REQ-005 SHALL have port Seg  input  7  active-low segments, bit order {a,b,c,d,e,f,g} (bit 0 = g).
REQ-006 SHALL have port PercOut  output  8  last decoded percentage value, binary.
REQ-007 SHALL have port ColorOut  output  4  last decoded color code: 0 r, 1 b, 2 G, 3 Y, 4 u/unknown.
REQ-008 SHALL have port FrameValid  output  1  one-cycle pulse when PercOut/ColorOut update.
REQ-009 SHALL have port FrameErr  output  1  qualified by FrameValid; the frame contained an invalid pattern or an overflow.

Function
REQ-010 SHALL register Dig/Seg once; a settle counter SHALL reset on any change of {Dig,Seg} and on any Dig value other than the four valid codes.
REQ-011 SHALL sample the digit exactly once per dwell, in the cycle the counter reaches SETTLE_CYCLES-1; no resample until {Dig,Seg} changes.
REQ-012 Numeric positions SHALL decode 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
REQ-013 Color position SHALL decode 1111010->0, 1100000->1, 0100001->2, 1001100->3, 1100011->4.
REQ-014 Any other pattern SHALL store digit 0 (numeric) or code 4 (color) and set the frame error flag.
REQ-015 SHALL track a 4-bit captured mask; a repeated position before completion SHALL overwrite the stored digit.
REQ-016 FSM states: COLLECT, CONV_H, CONV_T, CONV_O, PUBLISH; COLLECT->CONV_H in the cycle after the sample that completes the mask; then one state per cycle; PUBLISH->COLLECT.
REQ-017 Conversion: acc=H*100 in CONV_H, acc+=T*10 in CONV_T, acc+=O in CONV_O; acc SHALL be 10 bits.
REQ-018 acc>255 SHALL set the error flag and PercOut SHALL saturate to 255.
REQ-019 In PUBLISH: PercOut, ColorOut, FrameErr SHALL be loaded and FrameValid SHALL pulse high for exactly one cycle; latency is 4 cycles after the completing sample.
REQ-020 Samples arriving in CONV_H..PUBLISH SHALL be discarded; the mask and error flag SHALL clear on entry to COLLECT.
REQ-021 PercOut/ColorOut SHALL hold between frames.

Reset
REQ-022 On reset: PercOut=0, ColorOut=4, FrameValid=0, FrameErr=0, state=COLLECT, mask=0, settle counter=0, error flag=0.
REQ-023 Reset mid-conversion SHALL abort the frame with no FrameValid pulse.

Configuration
REQ-024 Macro DISP_CAPTURE_COLOR_EN defined: color position captured and decoded per REQ-013.
REQ-025 Macro undefined: color position ignored; the mask requires only the three numeric positions; ColorOut stays 4.

Structure
REQ-026 Shared package disp_pkg SHALL hold: Dig codes, segment pattern constants for 0-9 and r/b/G/Y/u, color code constants, COLOR_UNKNOWN=4.
REQ-027 Sub-module seg_decode SHALL be the combinational pattern->{nibble,valid} lookup, with a position-class input (numeric/color).

Verification
REQ-028 Scenario: drive color 1100000, digits 0,4,2 (each held 32 cycles) -> FrameValid once, PercOut=42, ColorOut=1, FrameErr=0.
REQ-029 Scenario: digits 2,9,9 -> PercOut=255, FrameErr=1.
REQ-030 Scenario: Dig held 15 cycles (SETTLE_CYCLES=16) then changed -> no sample; held 16 cycles -> sampled.
REQ-031 Scenario: tens pattern 1111111 -> FrameErr=1, tens treated as 0 (1,x,0 -> PercOut=100).
REQ-032 Scenario: reset asserted in CONV_T -> no FrameValid; outputs at reset values; the next full frame decodes normally.
REQ-033 Scenario: with DISP_CAPTURE_COLOR_EN undefined, digits 0,7,5 and no color digit -> PercOut=75, ColorOut=4.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the 7-segment display capture block.
// Holds digit-enable codes, segment patterns, color codes, FSM states.
package disp_pkg;

  localparam logic [3:0] DIG_COLOR = 4'b0111;
  localparam logic [3:0] DIG_HUND  = 4'b1011;
  localparam logic [3:0] DIG_TENS  = 4'b1101;
  localparam logic [3:0] DIG_ONES  = 4'b1110;
  localparam logic [3:0] DIG_NONE  = 4'b1111;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam logic [6:0] SEG_R = 7'b1111010;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_G = 7'b0100001;
  localparam logic [6:0] SEG_Y = 7'b1001100;
  localparam logic [6:0] SEG_U = 7'b1100011;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] COLOR_R       = 4'd0;
  localparam logic [3:0] COLOR_B       = 4'd1;
  localparam logic [3:0] COLOR_G       = 4'd2;
  localparam logic [3:0] COLOR_Y       = 4'd3;
  localparam logic [3:0] COLOR_UNKNOWN = 4'd4;

  typedef enum logic [2:0] {
    COLLECT,
    CONV_H,
    CONV_T,
    CONV_O,
    PUBLISH
  } state_t;

  function automatic logic dig_ok(input logic [3:0] d);
    return d inside {DIG_COLOR, DIG_HUND, DIG_TENS, DIG_ONES};
  endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode: segment pattern -> {nibble, valid} lookup.
// Ports: seg (active-low a..g), is_color (position class), nib, ok.
module seg_decode
  import disp_pkg::*;
(
  input  logic [6:0] seg,
  input  logic       is_color,
  output logic [3:0] nib,
  output logic       ok
);

  always_comb begin
    nib = 4'd0;
    ok  = 1'b1;
    if (is_color) begin
      case (seg)
        SEG_R:   nib = COLOR_R;
        SEG_B:   nib = COLOR_B;
        SEG_G:   nib = COLOR_G;
        SEG_Y:   nib = COLOR_Y;
        SEG_U:   nib = COLOR_UNKNOWN;
        default: begin
          nib = COLOR_UNKNOWN;
          ok  = 1'b0;
        end
      endcase
    end else begin
      case (seg)
        SEG_0:   nib = 4'd0;
        SEG_1:   nib = 4'd1;
        SEG_2:   nib = 4'd2;
        SEG_3:   nib = 4'd3;
        SEG_4:   nib = 4'd4;
        SEG_5:   nib = 4'd5;
        SEG_6:   nib = 4'd6;
        SEG_7:   nib = 4'd7;
        SEG_8:   nib = 4'd8;
        SEG_9:   nib = 4'd9;
        default: begin
          nib = 4'd0;
          ok  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/disp_capture.sv
// disp_capture: samples a multiplexed 7-seg display, decodes a frame.
// Ports: clk, reset (sync, high), Dig, Seg in; PercOut, ColorOut,
// FrameValid, FrameErr out. Macro DISP_CAPTURE_COLOR_EN adds color.
module disp_capture
  import disp_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Dig,
  input  logic [6:0] Seg,
  output logic [7:0] PercOut,
  output logic [3:0] ColorOut,
  output logic       FrameValid,
  output logic       FrameErr
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(SETTLE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

  logic [3:0]    dig_q;
  logic [6:0]    seg_q;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          samp;
  logic          is_color;
  logic [3:0]    nib;
  logic          ok;

  state_t     state;
  logic [3:0] mask;
  logic [3:0] mask_nxt;
  logic       err;
  logic       take;
  logic       full;
  logic [3:0] h, t, o;
  logic [9:0] acc;
`ifdef DISP_CAPTURE_COLOR_EN
  logic [3:0] col;
`endif

  // stable: the input matches last cycle's copy and names a real digit
  assign stable   = ({Dig, Seg} == {dig_q, seg_q}) && dig_ok(Dig);
  // fires on the single cycle the counter steps to SETTLE_CYCLES-1
  assign samp     = stable && (cnt == CNT_PRE);
  assign is_color = (dig_q == DIG_COLOR);

  seg_decode u_dec (
    .seg      (seg_q),
    .is_color (is_color),
    .nib      (nib),
    .ok       (ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q <= DIG_NONE;
      seg_q <= SEG_OFF;
      cnt   <= '0;
    end else begin
      dig_q <= Dig;
      seg_q <= Seg;
      if (!stable)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    take = samp && (state == COLLECT);
`ifndef DISP_CAPTURE_COLOR_EN
    if (is_color)
      take = 1'b0;
`endif
    mask_nxt = mask;
    if (take) begin
      unique case (1'b1)
        dig_q == DIG_COLOR: mask_nxt[3] = 1'b1;
        dig_q == DIG_HUND:  mask_nxt[2] = 1'b1;
        dig_q == DIG_TENS:  mask_nxt[1] = 1'b1;
        dig_q == DIG_ONES:  mask_nxt[0] = 1'b1;
        default: ;
      endcase
    end
`ifdef DISP_CAPTURE_COLOR_EN
    full = &mask_nxt;
`else
    full = &mask_nxt[2:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      mask       <= '0;
      err        <= 1'b0;
      h          <= '0;
      t          <= '0;
      o          <= '0;
      acc        <= '0;
`ifdef DISP_CAPTURE_COLOR_EN
      col        <= COLOR_UNKNOWN;
`endif
      PercOut    <= '0;
      ColorOut   <= COLOR_UNKNOWN;
      FrameValid <= 1'b0;
      FrameErr   <= 1'b0;
    end else begin
      FrameValid <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (take) begin
            mask <= mask_nxt;
            err  <= err | ~ok;
            if (dig_q == DIG_HUND) h <= nib;
            if (dig_q == DIG_TENS) t <= nib;
            if (dig_q == DIG_ONES) o <= nib;
`ifdef DISP_CAPTURE_COLOR_EN
            if (is_color) col <= nib;
`endif
            if (full) state <= CONV_H;
          end
        end
        CONV_H: begin
          acc   <= {6'd0, h} * 10'd100;
          state <= CONV_T;
        end
        CONV_T: begin
          acc   <= acc + {6'd0, t} * 10'd10;
          state <= CONV_O;
        end
        CONV_O: begin
          acc   <= acc + {6'd0, o};
          state <= PUBLISH;
        end
        PUBLISH: begin
          PercOut    <= (acc > 10'd255) ? 8'hFF : acc[7:0];
          FrameErr   <= err | (acc > 10'd255);
`ifdef DISP_CAPTURE_COLOR_EN
          ColorOut   <= col;
`else
          ColorOut   <= COLOR_UNKNOWN;
`endif
          FrameValid <= 1'b1;
          mask       <= '0;
          err        <= 1'b0;
          state      <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_capture.sv
// tb_disp_capture: directed bench for disp_capture.
// Drives digit dwells on negedge, checks outputs after each frame.
module tb_disp_capture;
  import disp_pkg::*;

`ifdef DISP_CAPTURE_COLOR_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Dig = DIG_NONE;
  logic [6:0] Seg = SEG_OFF;
  logic [7:0] PercOut;
  logic [3:0] ColorOut;
  logic       FrameValid;
  logic       FrameErr;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int fv_cnt = 0;
  int fv_cyc = 0;
  int t_ones = 0;
  int f0 = 0;

  always #5 clk = ~clk;

  disp_capture #(.SETTLE_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .Dig        (Dig),
    .Seg        (Seg),
    .PercOut    (PercOut),
    .ColorOut   (ColorOut),
    .FrameValid (FrameValid),
    .FrameErr   (FrameErr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (FrameValid) begin
      fv_cnt = fv_cnt + 1;
      fv_cyc = cyc;
    end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ecol(input int code);
    return CEN ? code : 4;
  endfunction

  task automatic hold(input logic [3:0] d, input logic [6:0] s,
                      input int n);
    Dig = d;
    Seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input bit wc, input logic [6:0] cs,
                       input logic [6:0] hs, input logic [6:0] ts,
                       input logic [6:0] os);
    if (wc) hold(DIG_COLOR, cs, 32);
    hold(DIG_HUND, hs, 32);
    hold(DIG_TENS, ts, 32);
    t_ones = cyc;
    hold(DIG_ONES, os, 32);
    hold(DIG_NONE, SEG_OFF, 8);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_perc", PercOut, 0);
    chk("rst_color", ColorOut, 4);
    chk("rst_fv", FrameValid, 0);
    chk("rst_err", FrameErr, 0);
    reset = 1'b0;
    @(negedge clk);

    f0 = fv_cnt;
    frame(1'b1, SEG_B, SEG_0, SEG_4, SEG_2);
    chk("f42_fv", fv_cnt - f0, 1);
    chk("f42_lat", fv_cyc - t_ones, 20);
    chk("f42_perc", PercOut, 42);
    chk("f42_color", ColorOut, ecol(1));
    chk("f42_err", FrameErr, 0);
    hold(DIG_NONE, SEG_OFF, 40);
    chk("hold_perc", PercOut, 42);
    chk("hold_fv", fv_cnt - f0, 1);

    f0 = fv_cnt;
    frame(1'b1, SEG_G, SEG_2, SEG_9, SEG_9);
    chk("f299_fv", fv_cnt - f0, 1);
    chk("f299_perc", PercOut, 255);
    chk("f299_err", FrameErr, 1);
    chk("f299_color", ColorOut, ecol(2));

    f0 = fv_cnt;
    frame(1'b1, SEG_R, SEG_1, SEG_OFF, SEG_0);
    chk("bad_fv", fv_cnt - f0, 1);
    chk("bad_perc", PercOut, 100);
    chk("bad_err", FrameErr, 1);

    f0 = fv_cnt;
    frame(CEN, SEG_Y, SEG_0, SEG_7, SEG_5);
    chk("f75_fv", fv_cnt - f0, 1);
    chk("f75_perc", PercOut, 75);
    chk("f75_color", ColorOut, ecol(3));
    chk("f75_err", FrameErr, 0);

    f0 = fv_cnt;
    hold(DIG_COLOR, SEG_U, 32);
    hold(DIG_HUND, SEG_9, 32);
    hold(DIG_HUND, SEG_1, 32);
    hold(DIG_TENS, SEG_2, 32);
    hold(DIG_ONES, SEG_3, 15);
    hold(DIG_NONE, SEG_OFF, 30);
    chk("short_fv", fv_cnt - f0, 0);
    hold(DIG_ONES, SEG_3, 16);
    hold(DIG_NONE, SEG_OFF, 10);
    chk("exact_fv", fv_cnt - f0, 1);
    chk("exact_perc", PercOut, 123);
    chk("exact_err", FrameErr, 0);
    chk("exact_color", ColorOut, ecol(4));

    f0 = fv_cnt;
    hold(DIG_COLOR, SEG_R, 32);
    hold(DIG_HUND, SEG_3, 32);
    hold(DIG_TENS, SEG_1, 32);
    hold(DIG_ONES, SEG_4, 17);
    reset = 1'b1;
    Dig = DIG_NONE;
    Seg = SEG_OFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold(DIG_NONE, SEG_OFF, 10);
    chk("abort_fv", fv_cnt - f0, 0);
    chk("abort_perc", PercOut, 0);
    chk("abort_color", ColorOut, 4);
    chk("abort_err", FrameErr, 0);

    f0 = fv_cnt;
    frame(1'b1, SEG_R, SEG_2, SEG_5, SEG_0);
    chk("post_fv", fv_cnt - f0, 1);
    chk("post_perc", PercOut, 250);
    chk("post_color", ColorOut, ecol(0));
    chk("post_err", FrameErr, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
